// File: rtl/frame_ctrl_pkg.sv
// Shared constants for the frame controller: enable-bus layout, channel and key indices,
// and the switch mapping for adjust channels and filter modes.
package frame_ctrl_pkg;

  localparam int unsigned CNT_W = 13;
  localparam int unsigned EN_W  = 32;
  localparam int unsigned SW_W  = 10;
  localparam int unsigned KEY_W = 4;

  localparam int unsigned EN_ADJ       = 0;
  localparam int unsigned EN_WR        = 1;
  localparam int unsigned EN_SHIFT     = 2;
  localparam int unsigned EN_FILT_BASE = 3;

  localparam int unsigned CH_BRI = 0;
  localparam int unsigned CH_CON = 1;

  localparam int unsigned KEY_INC = 0;
  localparam int unsigned KEY_DEC = 1;
  localparam int unsigned KEY_DEF = 3;

  // Channel select switches sit on odd SW bits (1, 3, ...), filter modes on even (2, 4, ...).
  function automatic int unsigned adj_sel_sw(input int unsigned ch);
    return 1 + 2 * ch;
  endfunction

  function automatic int unsigned filt_sw(input int unsigned f);
    return 2 + 2 * f;
  endfunction

endpackage

// File: rtl/frame_ctrl_if.sv
// Timing-counter inputs and control outputs of the frame controller.
interface frame_ctrl_if
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned N_ADJ = 2,
  parameter int unsigned LVL_W = 4
) ();

  logic [CNT_W-1:0]       row;
  logic [CNT_W-1:0]       col;
  logic [CNT_W-1:0]       x_count;
  logic [CNT_W-1:0]       y_count;
  logic [EN_W-1:0]        en;
  logic                   frame_en;
  logic                   binc;
  logic                   bdec;
  logic                   cinc;
  logic                   cdec;
  logic [N_ADJ*LVL_W-1:0] lvl;

  modport master (
    output row, col, x_count, y_count,
    input  en, frame_en, binc, bdec, cinc, cdec, lvl
  );

  modport slave (
    input  row, col, x_count, y_count,
    output en, frame_en, binc, bdec, cinc, cdec, lvl
  );

endinterface

// File: rtl/frame_ctrl_key_pulse.sv
// Two-flop synchroniser for an active-low push button with a one-cycle press strobe.
module key_pulse (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic [2:0] sync;

  always_ff @(posedge clk) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[1:0], key_n};
  end

  // sync[1] is the synchronised level; sync[2] is its previous value.
  always_comb press = sync[2] & ~sync[1];

endmodule

// File: rtl/frame_ctrl.sv
// Frame-boundary strobe, line-buffer enables, filter-mode shadow and saturating
// adjust levels; user requests are collected during a frame and committed at its boundary.
module frame_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SHIFT_X     = 781,
  parameter int unsigned SHIFT_Y_LIM = 528,
  parameter int unsigned N_ADJ       = 2,
  parameter int unsigned LVL_W       = 4,
  parameter int unsigned LVL_DEF     = 8,
  parameter int unsigned N_FILT      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  SW,
  input  logic [KEY_W-1:0] KEY,
  frame_ctrl_if.slave      bus
);

  logic [KEY_W-1:0]       press;
  logic                   frame_c;
  logic                   frame_q;
  logic                   wr_q;
  logic                   shift_q;
  logic [N_ADJ-1:0]       req_inc;
  logic [N_ADJ-1:0]       req_dec;
  logic [N_ADJ-1:0]       pend_inc;
  logic [N_ADJ-1:0]       pend_dec;
  logic [N_ADJ-1:0]       step_inc;
  logic [N_ADJ-1:0]       step_dec;
  logic                   pend_def;
  logic [N_FILT-1:0]      filt_sel;
  logic [N_FILT-1:0]      shadow;
  logic [N_ADJ*LVL_W-1:0] lvl_all;

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    key_pulse u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (KEY[k]),
      .press (press[k])
    );
  end

  always_comb frame_c = (bus.row == CNT_W'(V_ACTIVE)) && (bus.col == CNT_W'(H_ACTIVE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_q <= 1'b0;
      wr_q    <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      frame_q <= frame_c;
      wr_q    <= (bus.col < CNT_W'(H_ACTIVE));
      shift_q <= (bus.x_count == CNT_W'(SHIFT_X)) && (bus.y_count < CNT_W'(SHIFT_Y_LIM));
    end
  end

  for (genvar g = 0; g < N_ADJ; g++) begin : g_ch
    localparam int unsigned SEL = adj_sel_sw(g);
    logic [LVL_W-1:0] lvl_q;

    assign req_inc[g]  = press[KEY_INC] & SW[SEL];
    assign req_dec[g]  = press[KEY_DEC] & SW[SEL];
    assign step_inc[g] = frame_q & ~pend_def & pend_inc[g] & ~pend_dec[g] & (lvl_q != '1);
    assign step_dec[g] = frame_q & ~pend_def & pend_dec[g] & ~pend_inc[g] & (lvl_q != '0);

    always_ff @(posedge clk) begin
      if (!rst)                    lvl_q <= LVL_W'(LVL_DEF);
      else if (frame_q && pend_def) lvl_q <= LVL_W'(LVL_DEF);
      else if (step_inc[g])        lvl_q <= lvl_q + LVL_W'(1);
      else if (step_dec[g])        lvl_q <= lvl_q - LVL_W'(1);
    end

    assign lvl_all[g*LVL_W +: LVL_W] = lvl_q;
  end

  for (genvar f = 0; f < N_FILT; f++) begin : g_filt
    localparam int unsigned FSW = filt_sw(f);
    assign filt_sel[f] = SW[FSW];
  end

  // On commit the pending set is replaced by this cycle's events so a
  // press landing on the boundary carries into the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_inc <= '0;
      pend_dec <= '0;
      pend_def <= 1'b0;
      shadow   <= '0;
    end else if (frame_q) begin
      pend_inc <= req_inc;
      pend_dec <= req_dec;
      pend_def <= press[KEY_DEF];
      shadow   <= filt_sel;
    end else begin
      pend_inc <= pend_inc | req_inc;
      pend_dec <= pend_dec | req_dec;
      pend_def <= pend_def | press[KEY_DEF];
    end
  end

  always_comb begin
    bus.en                            = '0;
    bus.en[EN_ADJ]                    = |{step_inc, step_dec};
    bus.en[EN_WR]                     = wr_q;
    bus.en[EN_SHIFT]                  = shift_q;
    bus.en[EN_FILT_BASE +: N_FILT]    = shadow;
    bus.frame_en                      = frame_q;
    bus.binc                          = step_inc[CH_BRI];
    bus.bdec                          = step_dec[CH_BRI];
    bus.cinc                          = step_inc[CH_CON];
    bus.cdec                          = step_dec[CH_CON];
    bus.lvl                           = lvl_all;
  end

endmodule
